// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters plus a return address stack
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int RAS_DEPTH = 4,
  localparam int IDX = $clog2(ENTRIES),
  localparam int RW = $clog2(RAS_DEPTH),
  localparam int TW = 30 - IDX
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   pc_lookup,
  output logic          btb_hit,
  output logic          btb_predict_taken,
  output logic [31:0]   btb_target,
  input  logic          update_en,
  input  logic [31:0]   pc_update,
  input  logic [1:0]    upd_type,
  input  logic          upd_call,
  input  logic [31:0]   actual_target,
  input  logic          actual_taken,
  output logic [RW:0]   ras_count
);
  localparam logic [1:0] BR = 2'b00, JAL = 2'b01, RET = 2'b10;
  localparam logic [RW:0] FULL = (RW+1)'(RAS_DEPTH);
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TW-1:0] tag_q [ENTRIES], tag_d [ENTRIES];
  logic [31:0] tgt_q [ENTRIES], tgt_d [ENTRIES];
  logic [1:0] ctr_q [ENTRIES], ctr_d [ENTRIES];
  logic [1:0] typ_q [ENTRIES], typ_d [ENTRIES];
  logic [31:0] ras_q [RAS_DEPTH], ras_d [RAS_DEPTH];
  logic [RW-1:0] ptr_q, ptr_d;
  logic [RW:0] cnt_q, cnt_d;
  logic [IDX-1:0] l_idx, u_idx;
  logic [1:0] l_typ;
  logic [31:0] ras_top, link;
  logic u_hit, is_ret, unused_ok;
  assign unused_ok = ^pc_lookup[1:0];
  assign ras_count = cnt_q;
  // lookup path: reads only registered state, so same-cycle updates are not visible
  always_comb begin
    l_idx = pc_lookup[IDX+1:2];
    l_typ = typ_q[l_idx];
    ras_top = ras_q[ptr_q - 1'b1];
    btb_hit = valid_q[l_idx] && tag_q[l_idx] == pc_lookup[31:IDX+2];
    btb_predict_taken = btb_hit && (l_typ == JAL || (l_typ == BR && ctr_q[l_idx][1]) || (l_typ == RET && cnt_q != '0));
    btb_target = !btb_hit ? '0 : l_typ == RET ? ras_top : tgt_q[l_idx];
  end
  // resolve-time training of the BTB entry and the return stack
  always_comb begin
    valid_d = valid_q;
    tag_d = tag_q;
    tgt_d = tgt_q;
    ctr_d = ctr_q;
    typ_d = typ_q;
    ras_d = ras_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    u_idx = pc_update[IDX+1:2];
    u_hit = valid_q[u_idx] && tag_q[u_idx] == pc_update[31:IDX+2];
    is_ret = upd_type == RET;
    link = pc_update + 32'd4;
    if (update_en && upd_type != 2'b11) begin
      if (u_hit && typ_q[u_idx] == BR) begin
        ctr_d[u_idx] = actual_taken ? (ctr_q[u_idx] == 2'b11 ? 2'b11 : ctr_q[u_idx] + 2'b01)
                                    : (ctr_q[u_idx] == 2'b00 ? 2'b00 : ctr_q[u_idx] - 2'b01);
        if (actual_taken) tgt_d[u_idx] = actual_target;
      end else if (u_hit || actual_taken) begin
        valid_d[u_idx] = 1'b1;
        tag_d[u_idx] = pc_update[31:IDX+2];
        tgt_d[u_idx] = actual_target;
        typ_d[u_idx] = upd_type;
        ctr_d[u_idx] = upd_type == BR ? 2'b10 : 2'b11;
      end
      if (upd_call && is_ret && cnt_q != '0) begin
        ras_d[ptr_q - 1'b1] = link;
      end else if (upd_call) begin
        ras_d[ptr_q] = link;
        ptr_d = ptr_q + 1'b1;
        cnt_d = cnt_q == FULL ? cnt_q : cnt_q + 1'b1;
      end else if (is_ret && cnt_q != '0) begin
        ptr_d = ptr_q - 1'b1;
        cnt_d = cnt_q - 1'b1;
      end
    end
  end
  // control state: valid bits and stack pointer/count are the only reset state
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      valid_q <= valid_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
  // array payloads are qualified by valid/count, so they carry no reset
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
    ctr_q <= ctr_d;
    typ_q <= typ_d;
    ras_q <= ras_d;
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vectors checked through an expected-value scoreboard
module tb_branch_predictor;
  logic clk = 0, rst = 1;
  logic [31:0] pc_lookup = 0, pc_update = 0, actual_target = 0, btb_target;
  logic [1:0] upd_type = 0;
  logic update_en = 0, upd_call = 0, actual_taken = 0, btb_hit, btb_predict_taken;
  logic [2:0] ras_count;
  logic chk_v = 0;
  int total = 0, bad = 0;
  typedef struct packed {logic h; logic t; logic [31:0] g; logic mg; logic [2:0] c;} exp_t;
  exp_t q[$];
  exp_t e;
  branch_predictor #(.ENTRIES(16), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .pc_lookup(pc_lookup), .btb_hit(btb_hit),
    .btb_predict_taken(btb_predict_taken), .btb_target(btb_target),
    .update_en(update_en), .pc_update(pc_update), .upd_type(upd_type),
    .upd_call(upd_call), .actual_target(actual_target), .actual_taken(actual_taken),
    .ras_count(ras_count)
  );
  always #5 clk = ~clk;
  // monitor: compares the lookup outputs against the oldest queued expectation
  always @(negedge clk) begin
    if (chk_v) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty pc=%h", pc_lookup);
      end else begin
        e = q.pop_front();
        if (btb_hit !== e.h || btb_predict_taken !== e.t || ras_count !== e.c || (e.mg && btb_target !== e.g)) begin
          bad++;
          $display("FAIL lookup pc=%h got hit=%b taken=%b tgt=%h cnt=%0d exp hit=%b taken=%b tgt=%h(chk=%b) cnt=%0d",
                   pc_lookup, btb_hit, btb_predict_taken, btb_target, ras_count, e.h, e.t, e.g, e.mg, e.c);
        end
      end
    end
  end
  task automatic cyc(input logic en, input logic [31:0] pu, input logic [1:0] ty, input logic cl,
                     input logic [31:0] at, input logic tk, input logic chk, input logic [31:0] pl,
                     input logic eh, input logic et, input logic [31:0] eg, input logic mg, input logic [2:0] ec);
    update_en = en; pc_update = pu; upd_type = ty; upd_call = cl; actual_target = at; actual_taken = tk;
    pc_lookup = pl; chk_v = chk;
    if (chk) q.push_back('{eh, et, eg, mg, ec});
    @(posedge clk); #1;
    update_en = 0; chk_v = 0;
  endtask
  task automatic look(input logic [31:0] pl, input logic eh, input logic et, input logic [31:0] eg, input logic [2:0] ec);
    cyc(0, 0, 0, 0, 0, 0, 1, pl, eh, et, eg, 1, ec);
  endtask
  task automatic look_nt(input logic [31:0] pl, input logic eh, input logic et, input logic [2:0] ec);
    cyc(0, 0, 0, 0, 0, 0, 1, pl, eh, et, 0, 0, ec);
  endtask
  task automatic upd(input logic [31:0] pu, input logic [1:0] ty, input logic cl, input logic [31:0] at, input logic tk);
    cyc(1, pu, ty, cl, at, tk, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    look(32'h100, 0, 0, 0, 0);
    upd(32'h100, 2'b00, 0, 32'h80, 1);
    look(32'h100, 1, 1, 32'h80, 0);
    upd(32'h100, 2'b00, 0, 32'h80, 0);
    look(32'h100, 1, 0, 32'h80, 0);
    upd(32'h100, 2'b00, 0, 32'h80, 0);
    look(32'h100, 1, 0, 32'h80, 0);
    upd(32'h100, 2'b00, 0, 32'h80, 1);
    look(32'h100, 1, 0, 32'h80, 0);
    upd(32'h100, 2'b00, 0, 32'h80, 1);
    look(32'h100, 1, 1, 32'h80, 0);
    upd(32'h100, 2'b00, 0, 32'h80, 1);
    upd(32'h100, 2'b00, 0, 32'h80, 1);
    upd(32'h100, 2'b00, 0, 32'h80, 0);
    look(32'h100, 1, 1, 32'h80, 0);
    upd(32'h200, 2'b00, 0, 32'h900, 0);
    look(32'h200, 0, 0, 0, 0);
    look(32'h100, 1, 1, 32'h80, 0);
    upd(32'h140, 2'b00, 0, 32'h300, 1);
    look(32'h100, 0, 0, 0, 0);
    look(32'h140, 1, 1, 32'h300, 0);
    cyc(1, 32'h140, 2'b00, 0, 32'h500, 1, 1, 32'h140, 1, 1, 32'h300, 1, 0);
    look(32'h140, 1, 1, 32'h500, 0);
    upd(32'h700, 2'b11, 0, 32'h800, 1);
    look(32'h700, 0, 0, 0, 0);
    upd(32'h400, 2'b10, 0, 32'h0, 1);
    look_nt(32'h400, 1, 0, 0);
    upd(32'h10, 2'b00, 1, 0, 0);
    upd(32'h20, 2'b00, 1, 0, 0);
    upd(32'h30, 2'b00, 1, 0, 0);
    upd(32'h40, 2'b00, 1, 0, 0);
    look(32'h400, 1, 1, 32'h44, 4);
    upd(32'h50, 2'b00, 1, 0, 0);
    look(32'h400, 1, 1, 32'h54, 4);
    upd(32'h400, 2'b10, 0, 32'h0, 1);
    look(32'h400, 1, 1, 32'h44, 3);
    upd(32'h400, 2'b10, 0, 32'h0, 1);
    look(32'h400, 1, 1, 32'h34, 2);
    upd(32'h400, 2'b10, 0, 32'h0, 1);
    look(32'h400, 1, 1, 32'h24, 1);
    upd(32'h400, 2'b10, 0, 32'h0, 1);
    look_nt(32'h400, 1, 0, 0);
    upd(32'h400, 2'b10, 0, 32'h0, 1);
    look_nt(32'h400, 1, 0, 0);
    upd(32'h70, 2'b11, 1, 0, 0);
    look_nt(32'h400, 1, 0, 0);
    upd(32'h10, 2'b00, 1, 0, 0);
    look(32'h400, 1, 1, 32'h14, 1);
    upd(32'h60, 2'b10, 1, 0, 0);
    look(32'h400, 1, 1, 32'h64, 1);
    rst = 1;
    upd(32'h600, 2'b00, 0, 32'h900, 1);
    rst = 0;
    look(32'h600, 0, 0, 0, 0);
    look(32'h140, 0, 0, 0, 0);
    look(32'h400, 0, 0, 0, 0);
    @(posedge clk); #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch predictor for the pipelined core, a generalised successor to the fixed BTB. It pairs a direct-mapped branch target buffer of `ENTRIES` entries, holding 2-bit saturating counters and an entry type, with a `RAS_DEPTH` return address stack. It is looked up combinationally with the IF-stage PC. It is trained non-speculatively from the EX stage when a branch, JAL or return resolves.

## Interface
- `ENTRIES`, 16: BTB entries; power of two, 2..256; `IDX = log2(ENTRIES)`.
- `RAS_DEPTH`, 4: return stack entries; power of two, 2..16.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `pc_lookup` input 32: IF-stage PC.
- `btb_hit` output 1: a valid entry's tag matches `pc_lookup`.
- `btb_predict_taken` output 1: predict redirect.
- `btb_target` output 32: predicted target; 0 when `btb_hit`=0.
- `update_en` input 1: resolve event from EX.
- `pc_update` input 32: PC of the resolving instruction.
- `upd_type` input 2: 00 conditional branch, 01 JAL, 10 return (JALR), 11 reserved.
- `upd_call` input 1: the instruction links to x1/x5 (a call).
- `actual_target` input 32: resolved target.
- `actual_taken` input 1: resolved direction.
- `ras_count` output log2(RAS_DEPTH)+1: number of valid RAS entries, for debug.

## Operation
- Index is `pc[IDX+1:2]`. Tag is `pc[31:IDX+2]`. `pc[1:0]` is ignored.
- Each entry holds: valid, tag, target[31:0], ctr[1:0], type[1:0].
- Lookup is purely combinational:
  - `btb_hit` = valid & tag match.
  - `btb_predict_taken` = hit & (type==JAL | (type==BR & ctr[1]) | (type==RET & ras_count!=0)).
  - `btb_target` = type==RET ? RAS top : stored target.
- Update when `update_en`=1 and `upd_type`!=11:
  - Hit on a branch entry: ctr increments if taken and decrements if not, saturating at 00 and 11. Target is rewritten with `actual_target` when taken.
  - Hit on a non-branch entry: type, target and ctr are rewritten.
  - Miss, tag mismatch or invalid entry: allocate (overwrite) only if `actual_taken`=1. The new entry takes tag, target, type, and ctr=10 for a branch or 11 otherwise.
  - Miss with not-taken: no BTB write.
  - `upd_type`=11: no BTB or RAS change.
- RAS, when `update_en`=1:
  - Push `pc_update+4` if `upd_call`.
  - Pop if `upd_type`==10 & !`upd_call`.
  - Return that is also a call (jalr x1,x1): replace the top; count unchanged, or push if count is 0.
  - Push when full: circular overwrite of the oldest entry; count stays `RAS_DEPTH`.
  - Pop when empty: no change; count stays 0.
- The RAS is non-speculative. A flushed wrong-path instruction never reaches `update_en`, so no repair logic is needed.

## Timing
- Lookup has zero-cycle latency: outputs follow `pc_lookup` in the same cycle.
- Updates take effect at the clock edge. A lookup of the entry being updated in the same cycle returns the pre-update contents; the new value is visible the next cycle.
- RAS top seen by lookup is also pre-update in the update cycle.
- Reset values:
  - All valid bits 0, RAS pointer 0, `ras_count`=0.
  - Hence `btb_hit`=0, `btb_predict_taken`=0, `btb_target`=0 the cycle after reset.
- Reset asserted mid-stream overrides a simultaneous `update_en`.
- Only the valid bits and the RAS pointer/count need reset; array contents need not.
- No stalls. Back-to-back updates are accepted every cycle.

## Test plan
- **Reset, then cold lookup:** reset, then lookup 0x100 -> hit=0, taken=0, target=0.
- **Branch training:** update pc=0x100, type BR, taken, target 0x80.
  - Next cycle lookup 0x100 -> hit=1, taken=1, target=0x80.
  - Two not-taken updates -> ctr goes 10→01→00, taken=0 and hit=1 after the first.
  - Then three taken updates -> taken=1 after the second; ctr saturates at 11.
- **Not-taken miss does not allocate:** update pc=0x200, type BR, not-taken -> lookup 0x200 hit=0.
- **Alias replacement (ENTRIES=16):** train 0x100, then taken update at 0x140 with target 0x300.
  - Lookup 0x100 -> hit=0.
  - Lookup 0x140 -> target 0x300.
- **RAS (RAS_DEPTH=4):**
  - Five call pushes from pcs 0x10, 0x20, 0x30, 0x40, 0x50 -> count=4.
  - A return entry at 0x400 (allocated by a taken type-10 update) predicts 0x54, then 0x44, 0x34 and 0x24 as successive pops occur; count reaches 0.
  - Then predict_taken=0, and a further pop leaves count=0.
- **Same-cycle bypass check:** update and lookup 0x100 in the same cycle -> old value seen; new value seen next cycle. Reset asserted together with `update_en` -> no entry valid afterwards.
